// File: rtl/ft245_fifo_bridge.sv
// ft245_fifo_bridge: FT245-style parallel FIFO bridge between pads and SoC core.
// Synchronises TXE#/RXF#, sequences RD#/WR# with programmable timing, drives
// the data-bus output enable, and buffers traffic in TX/RX show-ahead FIFOs.
// Optional macro FT245_ARB_RR_EN: round-robin read/write arbitration
// (default build: fixed read priority).

// Show-ahead FIFO used for both traffic directions.
module ft245_fifo_bridge_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_cnt;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_cnt == LW'(DEPTH));
    assign empty     = (r_cnt == LW'(0));
    assign level     = r_cnt;
    assign rdata     = r_mem[r_rptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // Storage array: written on accepted push only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= AW'(0);
            r_rptr <= AW'(0);
            r_cnt  <= LW'(0);
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + LW'(1);
                2'b01:   r_cnt <= r_cnt - LW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module ft245_fifo_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int RD_PULSE    = 4,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 4,
    parameter int GAP         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
    input  logic [7:0]                    pad_data_i,
    output logic [7:0]                    pad_data_o,
    output logic                          pad_data_oe,
    input  logic                          pad_txe_n,
    input  logic                          pad_rxf_n,
    output logic                          pad_wr_n,
    output logic                          pad_rd_n
);
    localparam int M1   = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int M2   = (WR_SETUP > GAP) ? WR_SETUP : GAP;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    // Recovery must outlast the status synchroniser so arbitration never
    // acts on a stale RXF#/TXE# level from before the last transfer.
    generate
        if (GAP < SYNC_STAGES + 1) begin : g_gap_chk
            $error("GAP must be at least SYNC_STAGES+1");
        end
        if (SYNC_STAGES < 2) begin : g_sync_chk
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SU, S_WR, S_WR_HOLD, S_RECOVER
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_txe_sync;
    logic [SYNC_STAGES-1:0] r_rxf_sync;
    logic                 w_txe_s;
    logic                 w_rxf_s;
    logic                 w_rd_req;
    logic                 w_wr_req;
    logic                 w_pick_rd;
    logic                 w_pick_wr;
    logic                 w_rx_push;
    logic                 w_tx_pop;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic [7:0]           w_tx_head;
    logic                 r_rd_n;
    logic                 r_wr_n;
    logic                 r_oe;
    logic [7:0]           r_data_o;

    ft245_fifo_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_valid), .wdata(tx_data),
        .pop(w_tx_pop), .rdata(w_tx_head), .full(w_tx_full),
        .empty(w_tx_empty), .level(tx_level)
    );

    ft245_fifo_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(w_rx_push), .wdata(pad_data_i),
        .pop(rx_ready), .rdata(rx_data), .full(w_rx_full),
        .empty(w_rx_empty), .level(rx_level)
    );

    assign tx_ready    = ~w_tx_full;
    assign rx_valid    = ~w_rx_empty;
    assign pad_rd_n    = r_rd_n;
    assign pad_wr_n    = r_wr_n;
    assign pad_data_oe = r_oe;
    assign pad_data_o  = r_data_o;

    // Status pin synchronisers, idle (high) out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txe_sync <= {SYNC_STAGES{1'b1}};
            r_rxf_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_txe_sync <= {r_txe_sync[SYNC_STAGES-2:0], pad_txe_n};
            r_rxf_sync <= {r_rxf_sync[SYNC_STAGES-2:0], pad_rxf_n};
        end
    end

    assign w_txe_s  = r_txe_sync[SYNC_STAGES-1];
    assign w_rxf_s  = r_rxf_sync[SYNC_STAGES-1];
    assign w_rd_req = ~w_rxf_s & ~w_rx_full;
    assign w_wr_req = ~w_txe_s & ~w_tx_empty;

`ifdef FT245_ARB_RR_EN
    // 1 = read served last, 0 = write served last.
    logic r_last_grant;

    // Remember which direction was granted so contention alternates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (r_state == S_IDLE && w_pick_rd) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_pick_wr) begin
            r_last_grant <= 1'b0;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign w_pick_rd = w_rd_req & (~w_wr_req | ~r_last_grant);
`else
    assign w_pick_rd = w_rd_req;
`endif
    assign w_pick_wr = w_wr_req & ~w_pick_rd;

    // Next-state, counter reload and FIFO strobes for the transfer sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rx_push   = 1'b0;
        w_tx_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_rd) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = CW'(RD_PULSE - 1);
                end else if (w_pick_wr) begin
                    w_state_nxt = S_WR_SU;
                    w_cnt_nxt   = CW'(WR_SETUP - 1);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                if (r_cnt == CW'(0)) begin
                    w_rx_push   = 1'b1;
                    w_state_nxt = S_RECOVER;
                    w_cnt_nxt   = CW'(GAP - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WR_SU: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_WR;
                    w_cnt_nxt   = CW'(WR_PULSE - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WR: begin
                if (r_cnt == CW'(0)) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = S_WR_HOLD;
                    w_cnt_nxt   = CW'(0);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WR_HOLD: begin
                w_state_nxt = S_RECOVER;
                w_cnt_nxt   = CW'(GAP - 1);
            end
            S_RECOVER: begin
                if (r_cnt == CW'(0)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CW'(0);
            end
        endcase
    end

    // Sequencer state and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CW'(0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Pad outputs decoded from the next state so they switch with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_oe     <= 1'b0;
            r_data_o <= 8'h00;
        end else begin
            r_rd_n <= (w_state_nxt != S_RD);
            r_wr_n <= (w_state_nxt != S_WR);
            r_oe   <= (w_state_nxt == S_WR_SU) || (w_state_nxt == S_WR) ||
                      (w_state_nxt == S_WR_HOLD);
            if (r_state == S_IDLE && w_state_nxt == S_WR_SU) begin
                r_data_o <= w_tx_head;
            end else begin
                r_data_o <= r_data_o;
            end
        end
    end
endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed testbench for ft245_fifo_bridge with default parameters.
module tb_ft245_fifo_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] tx_level;
    logic [4:0] rx_level;
    logic [7:0] pad_data_i;
    logic [7:0] pad_data_o;
    logic       pad_data_oe;
    logic       pad_txe_n;
    logic       pad_rxf_n;
    logic       pad_wr_n;
    logic       pad_rd_n;

    int n_checks = 0;
    int n_pass   = 0;

    int rd_falls = 0;
    int wr_falls = 0;
    int repeats  = 0;
    int overlaps = 0;
    int oe_rd    = 0;
    bit prev_rd  = 1'b1;
    bit prev_wr  = 1'b1;
    bit last_rd  = 1'b1;

    int rd0, wr0, rep0;

    always #5 clk = ~clk;

    ft245_fifo_bridge dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .pad_data_i(pad_data_i), .pad_data_o(pad_data_o),
        .pad_data_oe(pad_data_oe), .pad_txe_n(pad_txe_n),
        .pad_rxf_n(pad_rxf_n), .pad_wr_n(pad_wr_n), .pad_rd_n(pad_rd_n)
    );

    // Strobe monitor: counts falling edges, back-to-back same-direction
    // transfers, and pad invariant violations.
    always @(negedge clk) begin
        if (pad_rd_n === 1'b0 && prev_rd) begin
            rd_falls <= rd_falls + 1;
            if (last_rd) repeats <= repeats + 1;
            last_rd <= 1'b1;
        end
        if (pad_wr_n === 1'b0 && prev_wr) begin
            wr_falls <= wr_falls + 1;
            if (!last_rd) repeats <= repeats + 1;
            last_rd <= 1'b0;
        end
        if (pad_rd_n === 1'b0 && pad_wr_n === 1'b0) overlaps <= overlaps + 1;
        if (pad_rd_n === 1'b0 && pad_data_oe === 1'b1) oe_rd <= oe_rd + 1;
        prev_rd <= (pad_rd_n !== 1'b0);
        prev_wr <= (pad_wr_n !== 1'b0);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        pad_data_i = 8'h00; pad_txe_n = 1'b1; pad_rxf_n = 1'b1;

        // 1. reset state
        wait_neg(3);
        check_eq("rst_rd_n", pad_rd_n, 1);
        check_eq("rst_wr_n", pad_wr_n, 1);
        check_eq("rst_oe", pad_data_oe, 0);
        check_eq("rst_data_o", pad_data_o, 8'h00);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_level", tx_level, 0);
        check_eq("rst_rx_level", rx_level, 0);
        reset = 1'b0;
        wait_neg(3);

        // 2. single read: RD# low for negedges k=3..6, byte visible at k=7
        pad_rxf_n = 1'b0; pad_data_i = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            wait_neg(1);
            check_eq($sformatf("rd_n_k%0d", k), pad_rd_n, (k >= 3 && k <= 6) ? 0 : 1);
            check_eq($sformatf("rd_oe_k%0d", k), pad_data_oe, 0);
            if (k == 6) check_eq("rd_rx_valid_early", rx_valid, 0);
            if (k == 7) begin
                check_eq("rd_rx_valid", rx_valid, 1);
                check_eq("rd_rx_data", rx_data, 8'hA5);
                check_eq("rd_rx_level", rx_level, 1);
            end
            if (k == 3) pad_rxf_n = 1'b1;
        end
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
        check_eq("rd_pop_level", rx_level, 0);
        wait_neg(8);

        // 3. single write: setup k=3, WR# low k=4..7, hold k=8, oe off k=9
        tx_data = 8'h3C; tx_valid = 1'b1;
        wait_neg(1);
        tx_valid = 1'b0;
        check_eq("wr_tx_level_push", tx_level, 1);
        pad_txe_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            wait_neg(1);
            check_eq($sformatf("wr_n_k%0d", k), pad_wr_n, (k >= 4 && k <= 7) ? 0 : 1);
            check_eq($sformatf("wr_oe_k%0d", k), pad_data_oe, (k >= 3 && k <= 8) ? 1 : 0);
            check_eq($sformatf("wr_rd_n_k%0d", k), pad_rd_n, 1);
            if (k == 3 || k == 8) check_eq($sformatf("wr_data_k%0d", k), pad_data_o, 8'h3C);
            if (k == 7) check_eq("wr_level_before_pop", tx_level, 1);
            if (k == 8) check_eq("wr_level_after_pop", tx_level, 0);
            if (k == 3) pad_txe_n = 1'b1;
        end
        wait_neg(8);

        // 4. RX full: exactly 16 reads, then one more per popped byte
        rd0 = rd_falls;
        pad_data_i = 8'h5A; pad_rxf_n = 1'b0;
        wait_neg(200);
        check_eq("full_reads", rd_falls - rd0, 16);
        check_eq("full_level", rx_level, 16);
        check_eq("full_rd_n_idle", pad_rd_n, 1);
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
        wait_neg(30);
        check_eq("full_reads_after_pop", rd_falls - rd0, 17);
        check_eq("full_level_after_pop", rx_level, 16);
        check_eq("full_head", rx_data, 8'h5A);
        pad_rxf_n = 1'b1;
        wait_neg(15);
        rx_ready = 1'b1;
        wait_neg(16);
        rx_ready = 1'b0;
        check_eq("drain_level", rx_level, 0);
        check_eq("drain_valid", rx_valid, 0);

        // 5. contention with bytes 01..04 waiting in TX
        for (int b = 1; b <= 4; b++) begin
            tx_data = 8'(b); tx_valid = 1'b1;
            wait_neg(1);
        end
        tx_valid = 1'b0;
        check_eq("cont_tx_level", tx_level, 4);
        rx_ready = 1'b1;
        rd0 = rd_falls; wr0 = wr_falls; rep0 = repeats;
        pad_rxf_n = 1'b0; pad_txe_n = 1'b0;
        wait_neg(70);
        pad_rxf_n = 1'b1; pad_txe_n = 1'b1;
        wait_neg(25);
`ifdef FT245_ARB_RR_EN
        check_eq("rr_some_writes", (wr_falls - wr0) >= 2, 1);
        check_eq("rr_some_reads", (rd_falls - rd0) >= 2, 1);
        check_eq("rr_alternate", repeats - rep0, 0);
`else
        check_eq("fixed_no_writes", wr_falls - wr0, 0);
        check_eq("fixed_reads", (rd_falls - rd0) >= 6, 1);
        check_eq("fixed_tx_level", tx_level, 4);
`endif
        check_eq("no_overlap", overlaps, 0);
        check_eq("no_oe_during_rd", oe_rd, 0);
        rx_ready = 1'b0;

        // 6. reset during the second WR# cycle
        tx_data = 8'h77; tx_valid = 1'b1;
        wait_neg(1);
        tx_valid = 1'b0;
        pad_txe_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_neg(1);
            if (k == 3) check_eq("rstwr_oe_setup", pad_data_oe, 1);
            if (k == 5) check_eq("rstwr_wr_n_low", pad_wr_n, 0);
        end
        reset = 1'b1;
        wait_neg(1);
        check_eq("rstwr_wr_n", pad_wr_n, 1);
        check_eq("rstwr_oe", pad_data_oe, 0);
        check_eq("rstwr_tx_level", tx_level, 0);
        check_eq("rstwr_tx_ready", tx_ready, 1);
        reset = 1'b0; pad_txe_n = 1'b1;
        wait_neg(10);
        check_eq("rstwr_idle_wr_n", pad_wr_n, 1);
        check_eq("rstwr_idle_oe", pad_data_oe, 0);
        check_eq("final_no_overlap", overlaps, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
